// File: rtl/muldiv_hilo_ctrl_if.sv
// rtl/muldiv_hilo_ctrl_if.sv - EX-stage muldiv/HI-LO bus between pipeline (master) and controller (slave)
interface muldiv_hilo_ctrl_if;
    logic        ex_valid;
    logic [3:0]  ex_hilo_rwen;
    logic        ex_mul_sign;
    logic        ex_div;
    logic [31:0] ex_src_a;
    logic [31:0] ex_src_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hilo_rdata;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Pipeline side: issues the decoded EX instruction, observes stall and HI/LO
    modport master (
        output ex_valid, ex_hilo_rwen, ex_mul_sign, ex_div, ex_src_a, ex_src_b, flush,
        input  stall, busy, hilo_rdata, hi_q, lo_q
    );

    // Controller side
    modport slave (
        input  ex_valid, ex_hilo_rwen, ex_mul_sign, ex_div, ex_src_a, ex_src_b, flush,
        output stall, busy, hilo_rdata, hi_q, lo_q
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - blocking multiply/restoring-divide sequencer with HI/LO registers (option: MULDIV_FAST_MUL_EN)
module muldiv_hilo_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_hilo_ctrl_if.slave bus
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    // r_rem: divider partial remainder / multiplier accumulator (upper product half)
    // r_quo: dividend shifting into quotient / multiplier shifting into lower product half
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_opd;
    logic [31:0] r_raw_a;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_divz;

    logic        w_is_muldiv;
    logic        w_start;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [33:0] w_add_x;
    logic [33:0] w_add_y;
    logic        w_add_cin;
    logic [33:0] w_add_sum;
    logic        w_borrow;
    logic [63:0] w_prod;
    logic [63:0] w_prod_c;
    logic [31:0] w_quo_c;
    logic [31:0] w_rem_c;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_prod;
`endif

    assign w_is_muldiv = (bus.ex_hilo_rwen == 4'b0011);
    assign w_start     = (r_state == ST_IDLE) & bus.ex_valid & w_is_muldiv & ~bus.flush;

    // Magnitudes are only taken for signed ops; unsigned operands pass through raw
    assign w_a_neg = bus.ex_mul_sign & bus.ex_src_a[31];
    assign w_b_neg = bus.ex_mul_sign & bus.ex_src_b[31];
    assign w_a_abs = w_a_neg ? (~bus.ex_src_a + 32'd1) : bus.ex_src_a;
    assign w_b_abs = w_b_neg ? (~bus.ex_src_b + 32'd1) : bus.ex_src_b;

`ifdef MULDIV_FAST_MUL_EN
    assign w_fast_prod = 64'(w_a_abs) * 64'(w_b_abs);
`endif

    // Shared adder: subtract divisor from shifted remainder, or add multiplicand to accumulator
    always_comb begin
        w_add_x   = {1'b0, r_rem, r_quo[31]};
        w_add_y   = ~{2'b00, r_opd};
        w_add_cin = 1'b1;
`ifndef MULDIV_FAST_MUL_EN
        if (!r_is_div) begin
            w_add_x   = {2'b00, r_rem};
            w_add_y   = r_quo[0] ? {2'b00, r_opd} : 34'd0;
            w_add_cin = 1'b0;
        end
`endif
        w_add_sum = w_add_x + w_add_y + {33'd0, w_add_cin};
    end

    // Partial remainder never exceeds 33 bits, so bit 33 set means the trial went negative
    assign w_borrow = w_add_sum[33];

    // Sign correction of the finished result, applied in DONE
    always_comb begin
        w_prod   = {r_rem, r_quo};
        w_prod_c = r_neg_res ? (~w_prod + 64'd1) : w_prod;
        w_quo_c  = r_neg_res ? (~r_quo + 32'd1) : r_quo;
        w_rem_c  = r_neg_rem ? (~r_rem + 32'd1) : r_rem;
        if (r_is_div) begin
            if (r_divz) begin
                w_res_hi = r_raw_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rem_c;
                w_res_lo = w_quo_c;
            end
        end else begin
            w_res_hi = w_prod_c[63:32];
            w_res_lo = w_prod_c[31:0];
        end
    end

    // Sequencer FSM with operand/datapath registers and the architectural HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_opd     <= '0;
            r_raw_a   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_divz    <= 1'b0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_is_div  <= bus.ex_div;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_raw_a   <= bus.ex_src_a;
                        r_divz    <= (bus.ex_src_b == 32'd0);
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (bus.ex_div) begin
                            r_rem   <= '0;
                            r_quo   <= w_a_abs;
                            r_opd   <= w_b_abs;
                            r_state <= ST_CALC;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            r_rem   <= w_fast_prod[63:32];
                            r_quo   <= w_fast_prod[31:0];
                            r_opd   <= w_a_abs;
                            r_state <= ST_DONE;
`else
                            r_rem   <= '0;
                            r_quo   <= w_b_abs;
                            r_opd   <= w_a_abs;
                            r_state <= ST_CALC;
`endif
                        end
                    end else if (bus.ex_valid) begin
                        if (bus.ex_hilo_rwen == 4'b0010) r_hi <= bus.ex_src_a;
                        if (bus.ex_hilo_rwen == 4'b0001) r_lo <= bus.ex_src_a;
                    end
                end
                ST_CALC: begin
                    if (r_is_div) begin
                        if (!w_borrow) begin
                            r_rem <= w_add_sum[31:0];
                            r_quo <= {r_quo[30:0], 1'b1};
                        end else begin
                            r_rem <= {r_rem[30:0], r_quo[31]};
                            r_quo <= {r_quo[30:0], 1'b0};
                        end
                    end
`ifndef MULDIV_FAST_MUL_EN
                    else begin
                        r_rem <= w_add_sum[32:1];
                        r_quo <= {w_add_sum[0], r_quo[31:1]};
                    end
`endif
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall = bus.ex_valid & w_is_muldiv & (r_state != ST_DONE) & ~bus.flush;
    assign bus.busy  = r_busy;
    assign bus.hi_q  = r_hi;
    assign bus.lo_q  = r_lo;
    assign bus.hilo_rdata = bus.ex_hilo_rwen[3] ? r_hi :
                            bus.ex_hilo_rwen[2] ? r_lo : 32'd0;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb/tb_muldiv_hilo_ctrl.sv - scoreboard bench for muldiv_hilo_ctrl
module tb_muldiv_hilo_ctrl;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif
    localparam int DIV_STALL = 33;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } exp_t;

    exp_t        q_hilo[$];
    logic [31:0] q_rd[$];
    logic        pend = 1'b0;

    muldiv_hilo_ctrl_if u_if ();

    muldiv_hilo_ctrl #(.DIV_CYCLES(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: result write one edge after the DONE cycle, read data whenever a read is presented
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (q_hilo.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h expected none", u_if.hi_q, u_if.lo_q);
                end else begin
                    e = q_hilo.pop_front();
                    chk({e.nm, "_hi"}, u_if.hi_q, e.hi);
                    chk({e.nm, "_lo"}, u_if.lo_q, e.lo);
                end
            end
            if (!rst && u_if.busy && !u_if.stall && !u_if.flush) pend = 1'b1;
            if (!rst && u_if.ex_valid && (u_if.ex_hilo_rwen == 4'b1000 || u_if.ex_hilo_rwen == 4'b0100)) begin
                if (q_rd.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_read: got %h expected none", u_if.hilo_rdata);
                end else begin
                    chk("hilo_rdata", u_if.hilo_rdata, q_rd.pop_front());
                end
            end
        end
    end

    task automatic idle();
        u_if.ex_valid     = 1'b0;
        u_if.ex_hilo_rwen = 4'b0000;
        u_if.ex_mul_sign  = 1'b0;
        u_if.ex_div       = 1'b0;
        u_if.ex_src_a     = '0;
        u_if.ex_src_b     = '0;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic dv);
        u_if.ex_valid     = 1'b1;
        u_if.ex_hilo_rwen = 4'b0011;
        u_if.ex_mul_sign  = sgn;
        u_if.ex_div       = dv;
        u_if.ex_src_a     = a;
        u_if.ex_src_b     = b;
    endtask

    // Issue a mult/div, count stall cycles, check HI/LO hold until DONE; leaves the op driven
    task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic dv,
                         input logic [31:0] eh, input logic [31:0] el, input int exp_stall);
        exp_t e;
        int   cnt;
        logic changed;
        logic [31:0] h0, l0;
        e.hi = eh; e.lo = el; e.nm = nm;
        q_hilo.push_back(e);
        drive_op(a, b, sgn, dv);
        h0 = u_if.hi_q;
        l0 = u_if.lo_q;
        cnt = 0;
        changed = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!u_if.stall) break;
            cnt++;
            if (u_if.hi_q !== h0 || u_if.lo_q !== l0) changed = 1'b1;
        end
        chk({nm, "_stall_cycles"}, cnt, exp_stall);
        chk({nm, "_hilo_hold"}, changed, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic mt(input logic hi, input logic [31:0] d);
        u_if.ex_valid     = 1'b1;
        u_if.ex_hilo_rwen = hi ? 4'b0010 : 4'b0001;
        u_if.ex_src_a     = d;
        @(negedge clk);
        chk("mt_stall", u_if.stall, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic hi, input logic [31:0] exp);
        q_rd.push_back(exp);
        u_if.ex_valid     = 1'b1;
        u_if.ex_hilo_rwen = hi ? 4'b1000 : 4'b0100;
        @(negedge clk);
        chk("mf_stall", u_if.stall, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        u_if.flush = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", u_if.stall, 1'b0);
        chk("rst_busy", u_if.busy, 1'b0);
        chk("rst_hi", u_if.hi_q, 32'd0);
        chk("rst_lo", u_if.lo_q, 32'd0);
        @(posedge clk); #1;
        rd(1'b1, 32'd0);
        idle();
        @(posedge clk); #1;

        // Back-to-back operations
        do_op("mult_neg3x5",  32'hFFFF_FFFD, 32'd5,        1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_STALL);
        do_op("multu_max_x2", 32'hFFFF_FFFF, 32'd2,        1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, MUL_STALL);
        do_op("mult_neg2xneg3", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'd0,      32'd6,         MUL_STALL);
        do_op("div_neg7_2",   32'hFFFF_FFF9, 32'd2,        1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_STALL);
        do_op("div_7_neg2",   32'd7,         32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1,        32'hFFFF_FFFD, DIV_STALL);
        do_op("divu_100_7",   32'd100,       32'd7,        1'b0, 1'b1, 32'd2,         32'd14,        DIV_STALL);
        do_op("divu_by_zero", 32'h1234_5678, 32'd0,        1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, DIV_STALL);
        do_op("div_by_zero_s", 32'hFFFF_FFFB, 32'd0,       1'b1, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_STALL);
        idle();
        @(posedge clk); #1;

        // Flush mid-divide
        mt(1'b1, 32'hA5A5_A5A5);
        rd(1'b1, 32'hA5A5_A5A5);
        drive_op(32'd100, 32'd7, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1 u_if.flush = 1'b1;
        @(negedge clk);
        chk("flush_stall_drop", u_if.stall, 1'b0);
        @(posedge clk); #1;
        u_if.flush = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_busy", u_if.busy, 1'b0);
        chk("flush_hi_kept", u_if.hi_q, 32'hA5A5_A5A5);
        @(posedge clk); #1;

        // Reset mid-divide
        drive_op(32'd100, 32'd7, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", u_if.busy, 1'b0);
        chk("midrst_hi", u_if.hi_q, 32'd0);
        chk("midrst_lo", u_if.lo_q, 32'd0);
        @(posedge clk); #1;

        // mtlo then immediate mflo, then overflow divide
        mt(1'b0, 32'h0000_0055);
        rd(1'b0, 32'h0000_0055);
        do_op("div_min_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 32'h8000_0000, DIV_STALL);
        idle();
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", q_hilo.size() + q_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
